// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings and counter constants for the gshare branch predictor.
package branch_pred_ctrl_pkg;

    // Next-fetch PC source select.
    typedef enum logic [1:0] {
        PCS_BTB   = 2'd0,
        PCS_SEQ   = 2'd1,
        PCS_E_TGT = 2'd2,
        PCS_E_SEQ = 2'd3
    } pc_src_e;

    // Weakly-not-taken value of a w-bit saturating counter (w in 2..4).
    function automatic logic [3:0] ctr_weak_nt(input int w);
        return 4'((1 << (w - 1)) - 1);
    endfunction

    // Saturation ceiling of a w-bit counter (w in 2..4).
    function automatic logic [3:0] ctr_max(input int w);
        return 4'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch-side lookup, execute-side resolution and statistics bundle of the predictor.
interface branch_pred_ctrl_if #(
    parameter int IDX_W  = 8,
    parameter int GHR_W  = 8,
    parameter int STAT_W = 32
);
    logic              i_F_valid;
    logic [31:0]       i_F_pc;
    logic              i_stall;
    logic              i_btb_hit;
    logic              i_btb_jump;
    logic              o_F_predict;
    logic [GHR_W-1:0]  o_F_ghr;
    logic [IDX_W-1:0]  o_F_idx;
    logic              i_E_branch;
    logic              i_E_jump;
    logic              i_E_taken;
    logic              i_E_predict;
    logic              i_E_target_ok;
    logic [GHR_W-1:0]  i_E_ghr;
    logic [IDX_W-1:0]  i_E_idx;
    logic [1:0]        o_PC_src;
    logic              o_mispredict;
    logic              o_update_BTB;
    logic              o_jump_btb;
    logic [STAT_W-1:0] o_br_cnt;
    logic [STAT_W-1:0] o_mis_cnt;

    modport master (
        output i_F_valid, i_F_pc, i_stall, i_btb_hit, i_btb_jump,
        output i_E_branch, i_E_jump, i_E_taken, i_E_predict, i_E_target_ok,
        output i_E_ghr, i_E_idx,
        input  o_F_predict, o_F_ghr, o_F_idx, o_PC_src, o_mispredict,
        input  o_update_BTB, o_jump_btb, o_br_cnt, o_mis_cnt
    );

    modport slave (
        input  i_F_valid, i_F_pc, i_stall, i_btb_hit, i_btb_jump,
        input  i_E_branch, i_E_jump, i_E_taken, i_E_predict, i_E_target_ok,
        input  i_E_ghr, i_E_idx,
        output o_F_predict, o_F_ghr, o_F_idx, o_PC_src, o_mispredict,
        output o_update_BTB, o_jump_btb, o_br_cnt, o_mis_cnt
    );
endinterface

// File: rtl/branch_pred_ctrl_sat_counter.sv
// Up/down counter next-value logic that sticks at zero and at a ceiling.
module sat_counter #(
    parameter int           W   = 2,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    // Step toward the requested direction unless already at that end.
    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != MAX) begin
            nxt = cur + W'(1);
        end else if (dec && !inc && cur != '0) begin
            nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Gshare direction predictor with speculative global history, mispredict recovery
// and resolved-branch / mispredict statistics.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int GHR_W  = 8,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 32
) (
    input logic               i_clk,
    input logic               i_rst,
    branch_pred_ctrl_if.slave bus
);

    localparam int               PHT_D   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_TOP = CTR_W'(ctr_max(CTR_W));

    logic [CTR_W-1:0]  pht [PHT_D];
    logic [CTR_W-1:0]  pht_next;
    logic [GHR_W-1:0]  ghr;
    logic [IDX_W-1:0]  f_idx;
    logic [STAT_W-1:0] br_cnt;
    logic [STAT_W-1:0] br_cnt_next;
    logic [STAT_W-1:0] mis_cnt;
    logic [STAT_W-1:0] mis_cnt_next;
    logic              predict;
    logic              e_branch;
    logic              e_jump;
    logic              e_resolve;
    logic              mispredict;
    logic              spec_shift;
    logic              pc_unused;
    pc_src_e           pc_src;

    // Only the word-index bits of the fetch PC feed the hash.
    assign pc_unused = ^{bus.i_F_pc[31:IDX_W+2], bus.i_F_pc[1:0]};

    // A simultaneous branch+jump is handled purely as a jump.
    assign e_jump    = bus.i_E_jump;
    assign e_branch  = bus.i_E_branch & ~bus.i_E_jump;
    assign e_resolve = bus.i_E_branch | bus.i_E_jump;

    assign f_idx      = bus.i_F_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign predict    = bus.i_btb_hit & (bus.i_btb_jump | pht[f_idx][CTR_W-1]);
    assign spec_shift = bus.i_F_valid & bus.i_btb_hit & ~bus.i_btb_jump & ~bus.i_stall;

    // Flag a wrong direction or wrong target for whatever resolved in E.
    always_comb begin
        mispredict = 1'b0;
        if (e_jump) begin
            mispredict = ~bus.i_E_predict | ~bus.i_E_target_ok;
        end else if (e_branch) begin
            mispredict = (bus.i_E_taken != bus.i_E_predict) |
                         (bus.i_E_taken & ~bus.i_E_target_ok);
        end
    end

    // Redirect from E outranks the fetch-side prediction.
    always_comb begin
        pc_src = PCS_SEQ;
        if (mispredict) begin
            pc_src = (bus.i_E_taken || e_jump) ? PCS_E_TGT : PCS_E_SEQ;
        end else if (predict) begin
            pc_src = PCS_BTB;
        end
    end

    // History register: recovery from the E checkpoint wins over the speculative shift.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= e_branch ? GHR_W'({bus.i_E_ghr, bus.i_E_taken}) : bus.i_E_ghr;
        end else if (spec_shift) begin
            ghr <= GHR_W'({ghr, predict});
        end
    end

    sat_counter #(.W(CTR_W), .MAX(CTR_TOP)) u_pht_ctr (
        .cur (pht[bus.i_E_idx]),
        .inc (bus.i_E_taken),
        .dec (~bus.i_E_taken),
        .nxt (pht_next)
    );

    // Train the counter of every resolving conditional branch, mispredicted or not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PHT_D; i++) begin
                pht[i] <= CTR_WNT;
            end
        end else if (e_branch) begin
            pht[bus.i_E_idx] <= pht_next;
        end
    end

    sat_counter #(.W(STAT_W)) u_br_stat (
        .cur (br_cnt),
        .inc (e_resolve),
        .dec (1'b0),
        .nxt (br_cnt_next)
    );

    sat_counter #(.W(STAT_W)) u_mis_stat (
        .cur (mis_cnt),
        .inc (mispredict),
        .dec (1'b0),
        .nxt (mis_cnt_next)
    );

    // Statistics registers, saturating at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            br_cnt  <= br_cnt_next;
            mis_cnt <= mis_cnt_next;
        end
    end

    assign bus.o_F_predict  = predict;
    assign bus.o_F_ghr      = ghr;
    assign bus.o_F_idx      = f_idx;
    assign bus.o_PC_src     = pc_src;
    assign bus.o_mispredict = mispredict;
    assign bus.o_update_BTB = e_resolve;
    assign bus.o_jump_btb   = bus.i_E_jump;
    assign bus.o_br_cnt     = br_cnt;
    assign bus.o_mis_cnt    = mis_cnt;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl against an arithmetic reference model.
module tb_branch_pred_ctrl;

    localparam int IDX_W    = 8;
    localparam int GHR_W    = 8;
    localparam int CTR_W    = 2;
    localparam int STAT_W   = 4;
    localparam int PHT_D    = 256;
    localparam int CTR_TOP  = 3;
    localparam int STAT_TOP = 15;

    logic i_clk = 1'b0;
    logic i_rst;

    int checks   = 0;
    int failures = 0;

    // Reference state.
    int m_ghr;
    int m_br;
    int m_mis;
    int m_pht [PHT_D];

    // Current stimulus copy.
    int s_valid, s_pc, s_stall, s_hit, s_bjmp;
    int s_eb, s_ej, s_et, s_ep, s_eok, s_eghr, s_eidx;

    // Expected combinational results for the current cycle.
    int x_idx, x_pred, x_mis, x_pcs, x_br, x_jmp;

    branch_pred_ctrl_if #(.IDX_W(IDX_W), .GHR_W(GHR_W), .STAT_W(STAT_W)) bus ();

    branch_pred_ctrl #(.IDX_W(IDX_W), .GHR_W(GHR_W), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int valid, input int pc, input int stall, input int hit,
                                 input int bjmp, input int eb, input int ej, input int et,
                                 input int ep, input int eok, input int eghr, input int eidx);
        s_valid = valid; s_pc = pc; s_stall = stall; s_hit = hit; s_bjmp = bjmp;
        s_eb = eb; s_ej = ej; s_et = et; s_ep = ep; s_eok = eok; s_eghr = eghr; s_eidx = eidx;
        bus.i_F_valid     = 1'(valid);
        bus.i_F_pc        = 32'(pc);
        bus.i_stall       = 1'(stall);
        bus.i_btb_hit     = 1'(hit);
        bus.i_btb_jump    = 1'(bjmp);
        bus.i_E_branch    = 1'(eb);
        bus.i_E_jump      = 1'(ej);
        bus.i_E_taken     = 1'(et);
        bus.i_E_predict   = 1'(ep);
        bus.i_E_target_ok = 1'(eok);
        bus.i_E_ghr       = 8'(eghr);
        bus.i_E_idx       = 8'(eidx);
    endtask

    task automatic modelReset();
        for (int i = 0; i < PHT_D; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic evalComb(input string tag);
        #1;
        x_jmp  = s_ej;
        x_br   = (s_eb != 0 && s_ej == 0) ? 1 : 0;
        x_idx  = ((s_pc >>> 2) & 8'hFF) ^ m_ghr;
        x_pred = (s_hit != 0 && (s_bjmp != 0 || m_pht[x_idx] >= (CTR_TOP + 1) / 2)) ? 1 : 0;
        x_mis  = 0;
        if (x_br != 0 && (s_et != s_ep || (s_et != 0 && s_eok == 0))) x_mis = 1;
        if (x_jmp != 0 && (s_ep == 0 || s_eok == 0)) x_mis = 1;
        if (x_mis != 0) x_pcs = (s_et != 0 || x_jmp != 0) ? 2 : 3;
        else            x_pcs = (x_pred != 0) ? 0 : 1;
        checkOutput({tag, "_idx"},   32'(bus.o_F_idx),      32'(x_idx));
        checkOutput({tag, "_pred"},  32'(bus.o_F_predict),  32'(x_pred));
        checkOutput({tag, "_ghr"},   32'(bus.o_F_ghr),      32'(m_ghr));
        checkOutput({tag, "_pcsrc"}, 32'(bus.o_PC_src),     32'(x_pcs));
        checkOutput({tag, "_mis"},   32'(bus.o_mispredict), 32'(x_mis));
        checkOutput({tag, "_updb"},  32'(bus.o_update_BTB), 32'((s_eb != 0 || s_ej != 0) ? 1 : 0));
        checkOutput({tag, "_jbtb"},  32'(bus.o_jump_btb),   32'(s_ej));
    endtask

    task automatic clockEdge(input string tag);
        @(posedge i_clk);
        if (x_mis != 0) begin
            m_ghr = (x_br != 0) ? (((s_eghr << 1) | s_et) & 8'hFF) : s_eghr;
        end else if (s_valid != 0 && s_hit != 0 && s_bjmp == 0 && s_stall == 0) begin
            m_ghr = ((m_ghr << 1) | x_pred) & 8'hFF;
        end
        if (x_br != 0) begin
            if (s_et != 0) m_pht[s_eidx] = (m_pht[s_eidx] < CTR_TOP) ? m_pht[s_eidx] + 1 : CTR_TOP;
            else           m_pht[s_eidx] = (m_pht[s_eidx] > 0) ? m_pht[s_eidx] - 1 : 0;
        end
        if ((s_eb != 0 || s_ej != 0) && m_br < STAT_TOP) m_br++;
        if (x_mis != 0 && m_mis < STAT_TOP) m_mis++;
        #1;
        checkOutput({tag, "_ghr_q"}, 32'(bus.o_F_ghr),   32'(m_ghr));
        checkOutput({tag, "_brcnt"}, 32'(bus.o_br_cnt),  32'(m_br));
        checkOutput({tag, "_miscnt"}, 32'(bus.o_mis_cnt), 32'(m_mis));
    endtask

    // Reset asserted mid-cycle while the applied stimulus has writes pending.
    task automatic midReset(input string tag);
        evalComb({tag, "_pre"});
        i_rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, "_ghr0"}, 32'(bus.o_F_ghr),   32'd0);
        checkOutput({tag, "_br0"},  32'(bus.o_br_cnt),  32'd0);
        checkOutput({tag, "_mis0"}, 32'(bus.o_mis_cnt), 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput({tag, "_ghr1"}, 32'(bus.o_F_ghr),   32'd0);
        checkOutput({tag, "_mis1"}, 32'(bus.o_mis_cnt), 32'd0);
        i_rst = 1'b0;
    endtask

    initial begin
        int r;
        int eb;
        int ej;

        // Power-on reset with idle inputs.
        i_rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        evalComb("reset");
        checkOutput("reset_pcsrc_lit", 32'(bus.o_PC_src),  32'd1);
        checkOutput("reset_brcnt",     32'(bus.o_br_cnt),  32'd0);
        checkOutput("reset_miscnt",    32'(bus.o_mis_cnt), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // First lookup after reset at PC 0x100.
        applyStimulus(1, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        evalComb("first");
        checkOutput("first_pred_lit", 32'(bus.o_F_predict), 32'd0);
        checkOutput("first_pcs_lit",  32'(bus.o_PC_src),    32'd1);
        checkOutput("first_idx_lit",  32'(bus.o_F_idx),     32'h40);
        clockEdge("first");

        // Four correctly predicted taken resolves saturate index 0x40.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 8'h40);
            evalComb("train");
            clockEdge("train");
        end

        // Jump recovery forces the history to zero, then re-fetch 0x100.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        evalComb("recov");
        clockEdge("recov");
        checkOutput("recov_ghr_lit", 32'(bus.o_F_ghr), 32'd0);
        applyStimulus(1, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        evalComb("sat");
        checkOutput("sat_pred_lit", 32'(bus.o_F_predict), 32'd1);
        checkOutput("sat_pcs_lit",  32'(bus.o_PC_src),    32'd0);
        clockEdge("sat");

        // Fetch shift and E recovery on the same edge: recovery wins.
        applyStimulus(1, 32'h104, 0, 1, 0, 1, 0, 0, 1, 1, 8'h05, 8'h20);
        evalComb("race");
        checkOutput("race_ghrin_lit", 32'(bus.o_F_ghr),     32'h01);
        checkOutput("race_pred_lit",  32'(bus.o_F_predict), 32'd1);
        checkOutput("race_pcs_lit",   32'(bus.o_PC_src),    32'd3);
        clockEdge("race");
        checkOutput("race_ghr_lit",   32'(bus.o_F_ghr),     32'h0A);

        // Jump predicted not-taken.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h0A, 0);
        evalComb("jmp");
        checkOutput("jmp_mis_lit",  32'(bus.o_mispredict), 32'd1);
        checkOutput("jmp_pcs_lit",  32'(bus.o_PC_src),     32'd2);
        checkOutput("jmp_updb_lit", 32'(bus.o_update_BTB), 32'd1);
        checkOutput("jmp_jbtb_lit", 32'(bus.o_jump_btb),   32'd1);
        clockEdge("jmp");
        checkOutput("jmp_miscnt_lit", 32'(bus.o_mis_cnt), 32'd3);

        // Randomized traffic, including the illegal branch+jump combination.
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            eb = (r <= 4 || r == 7) ? 1 : 0;
            ej = (r == 5 || r == 6 || r == 7) ? 1 : 0;
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom & 32'hFFFF_F03C),
                          (($urandom_range(0, 3) == 0) ? 1 : 0), int'($urandom_range(0, 1)),
                          (($urandom_range(0, 4) == 0) ? 1 : 0), eb, ej,
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          (($urandom_range(0, 3) != 0) ? 1 : 0), int'($urandom_range(0, 255)),
                          (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                                       : int'($urandom_range(0, 15))));
            evalComb("rnd");
            clockEdge("rnd");
        end

        // Clear, retrain 0x40, then saturate the mispredict counter.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        midReset("clr");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 8'h40);
            evalComb("retrain");
            clockEdge("retrain");
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, int'($urandom_range(0, 255)), 0);
            evalComb("mis20");
            clockEdge("mis20");
        end
        checkOutput("mis20_sat_lit", 32'(bus.o_mis_cnt), 32'd15);
        checkOutput("br_sat_lit",    32'(bus.o_br_cnt),  32'd15);

        // Reset lands while a branch recovery and PHT write are pending.
        applyStimulus(1, 32'h100, 0, 1, 0, 1, 0, 1, 0, 1, 8'h33, 8'h40);
        midReset("midrst");
        applyStimulus(1, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        evalComb("post");
        checkOutput("post_pred_lit", 32'(bus.o_F_predict), 32'd0);
        checkOutput("post_idx_lit",  32'(bus.o_F_idx),     32'h40);
        checkOutput("post_pcs_lit",  32'(bus.o_PC_src),    32'd1);
        clockEdge("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 Parameter IDX_W, default 8, PHT index width; PHT depth SHALL be 2^IDX_W.
REQ-002 Parameter GHR_W, default 8, global history width; legal range SHALL be 1..IDX_W.
REQ-003 Parameter CTR_W, default 2, PHT saturating-counter width, legal range 2..4.
REQ-004 Parameter STAT_W, default 32, width of the statistics counters.
REQ-005 Ports SHALL be as follows. One clock; reset is asynchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_F_valid  in  1  fetch PC valid.
- i_F_pc  in  32  fetch PC.
- i_stall  in  1  fetch frozen.
- i_btb_hit  in  1  BTB hit for i_F_pc.
- i_btb_jump  in  1  hit entry is an unconditional jump.
- o_F_predict  out  1  predict taken.
- o_F_ghr  out  GHR_W  pre-update history checkpoint.
- o_F_idx  out  IDX_W  PHT index used.
- i_E_branch  in  1  conditional branch resolving in E.
- i_E_jump  in  1  jump resolving in E.
- i_E_taken  in  1  actual outcome.
- i_E_predict  in  1  piped prediction.
- i_E_target_ok  in  1  BTB target matched actual target.
- i_E_ghr  in  GHR_W  piped checkpoint.
- i_E_idx  in  IDX_W  piped index.
- o_PC_src  out  2  0 = BTB target, 1 = PC+4, 2 = E actual target, 3 = E PC+4.
- o_mispredict  out  1  flush request.
- o_update_BTB  out  1  BTB write enable.
- o_jump_btb  out  1  BTB jump flag to write.
- o_br_cnt  out  STAT_W  resolved branch and jump count.
- o_mis_cnt  out  STAT_W  mispredict count.

Function
REQ-006 The PHT SHALL hold 2^IDX_W registers of CTR_W bits each; predict-taken SHALL be the counter MSB.
REQ-007 o_F_idx SHALL equal i_F_pc[IDX_W+1:2] XOR the GHR zero-extended to IDX_W bits; the lookup SHALL be combinational.
REQ-008 o_F_predict SHALL be 1 if i_btb_hit and i_btb_jump are both 1; it SHALL also be 1 if i_btb_hit=1 and the PHT MSB=1; otherwise 0.
REQ-009 o_F_ghr SHALL equal the current GHR register, before any update.
REQ-010 Speculative history update: on an edge with i_F_valid=1, i_btb_hit=1, i_btb_jump=0, i_stall=0 and o_mispredict=0, GHR SHALL become {GHR[GHR_W-2:0], o_F_predict}.
REQ-011 o_mispredict SHALL be combinational and equal 1 in either case:
- i_E_branch=1 and (i_E_taken != i_E_predict, or i_E_taken=1 with i_E_target_ok=0);
- i_E_jump=1 and (i_E_predict=0 or i_E_target_ok=0).
REQ-012 Recovery: on an edge with o_mispredict=1 and i_E_branch=1, GHR SHALL become {i_E_ghr[GHR_W-2:0], i_E_taken}. If i_E_jump=1 instead, GHR SHALL become i_E_ghr. Recovery SHALL override the REQ-010 update in the same cycle.
REQ-013 PHT update: on an edge with i_E_branch=1, entry i_E_idx SHALL increment if i_E_taken=1 and decrement otherwise.
- The counter SHALL saturate at all-ones and at zero.
- This update occurs whether or not the branch was mispredicted.
REQ-014 Same-cycle fetch read and E write of one index: the fetch read SHALL return the pre-write value (no bypass).
REQ-015 o_PC_src priority, highest first:
- o_mispredict=1 and i_E_taken=1 (or jump): 2;
- o_mispredict=1 and i_E_taken=0: 3;
- o_F_predict=1: 0;
- otherwise: 1.
REQ-016 o_update_BTB SHALL be i_E_branch OR i_E_jump. o_jump_btb SHALL be i_E_jump.
REQ-017 o_br_cnt SHALL increment when i_E_branch OR i_E_jump is 1. o_mis_cnt SHALL increment when o_mispredict is 1. Both counters SHALL saturate at all-ones.
REQ-018 i_E_branch and i_E_jump both 1 is illegal; if it occurs, the block SHALL treat the instruction as a jump.

Reset
REQ-019 While i_rst=1, the block SHALL asynchronously set:
- GHR to 0;
- every PHT entry to weakly-not-taken, 2^(CTR_W-1)-1;
- o_br_cnt and o_mis_cnt to 0.
REQ-020 The combinational outputs SHALL follow their definitions from the reset state; for example, o_PC_src=1 with no E activity and no BTB hit.
REQ-021 A reset asserted mid-recovery SHALL discard the pending GHR and PHT writes.

Structure
REQ-022 A shared package SHALL hold:
- the PC_src encodings (PCS_BTB=0, PCS_SEQ=1, PCS_E_TGT=2, PCS_E_SEQ=3);
- the CTR_W-dependent constants for weakly-not-taken and counter max.
REQ-023 A sub-module sat_counter SHALL implement the parametrised increment/decrement saturation logic; it SHALL be used both for the PHT next-value and for the statistics counters.

Verification
REQ-024 After reset with i_btb_hit=1, i_btb_jump=0 and PC 0x100: o_F_predict=0, o_PC_src=1, o_F_idx=0x40.
REQ-025 Four taken resolves at idx 0x40, then the same fetch with GHR forced to 0 by reset-free recovery: the counter reads 3 (saturated), o_F_predict=1, o_PC_src=0.
REQ-026 Fetch update with GHR=0x01 and predict=1, while the same edge has an E mispredict with i_E_ghr=0x05, i_E_taken=0: GHR becomes 0x0A, o_PC_src=3 during that cycle.
REQ-027 i_E_jump=1, i_E_predict=0: o_mispredict=1, o_PC_src=2, o_update_BTB=1, o_jump_btb=1, o_mis_cnt increments by 1.
REQ-028 With STAT_W=4: 20 mispredicts leave o_mis_cnt=15; assert i_rst mid-sequence and all counters, GHR and PHT read their reset values on the next cycle.
